// File: rtl/sal_ddr2_pkg.sv
// Shared types and defaults for the DDR2 read-return path.
// The tag id field width fixes the widest AXI ID the tag FIFO can carry.
package sal_ddr2_pkg;

    localparam int DEF_DATA_W     = 128;
    localparam int DEF_ID_W       = 4;
    localparam int DEF_TAG_DEPTH  = 8;
    localparam int DEF_DATA_DEPTH = 16;
    localparam int LEN_W          = 4;
    localparam int TAG_ID_W       = DEF_ID_W;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    typedef struct packed {
        logic [TAG_ID_W-1:0] id;
        logic [LEN_W-1:0]    len;
    } rd_tag_t;

    // Number of data beats a command occupies (len is beats minus one).
    function automatic logic [LEN_W:0] beats_of(input logic [LEN_W-1:0] len);
        return (LEN_W+1)'(len) + (LEN_W+1)'(1);
    endfunction

endpackage

// File: rtl/sal_sync_fifo.sv
// Synchronous FIFO with a registered head word: rd_data_o always holds the
// oldest entry, so a word written into an empty FIFO is visible next cycle.
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);

    // Pointers wrap naturally, so DEPTH is expected to be a power of two.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign rd_data_o = head_q;

    always_comb begin
        pop      = rd_en_i && !empty_o;
        push     = wr_en_i && (!full_o || pop);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        wr_ptr_d = wr_ptr_q + AW'(push);
        count_d  = count_q + CW'(push) - CW'(pop);
        // The new head is the incoming word when the FIFO is (or becomes) empty.
        head_d   = (push && (wr_ptr_q == rd_ptr_d)) ? wr_data_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
        head_q <= head_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sal_dfi_rd_return.sv
// DFI read-data return: buffers unstallable DFI beats and replays them as AXI R
// bursts, using a tag FIFO of issued commands and a beat reservation counter.
module sal_dfi_rd_return
    import sal_ddr2_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ID_W       = DEF_ID_W,
    parameter int TAG_DEPTH  = DEF_TAG_DEPTH,
    parameter int DATA_DEPTH = DEF_DATA_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ID_W-1:0]   cmd_id,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              dfi_rddata_valid,
    input  logic [DATA_W-1:0] dfi_rddata,
    output logic              rvalid,
    input  logic              rready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              ovf_err
);

    localparam int RW = $clog2(DATA_DEPTH + 1);

    rd_tag_t           tag_in;
    rd_tag_t           tag_head;
    logic              tag_full, tag_empty;
    logic [DATA_W-1:0] data_head;
    logic              data_full, data_empty;

    logic [RW-1:0]     resv_q, resv_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic              ovf_q, ovf_d;

    logic              fits;
    logic              cmd_acc;
    logic              r_hs;
    logic              head_last;

    always_comb begin
        tag_in.id  = TAG_ID_W'(cmd_id);
        tag_in.len = cmd_len;
    end

    // A command is only taken if every one of its beats already has a buffer slot.
    assign fits      = ((RW+1)'(resv_q) + (RW+1)'(beats_of(cmd_len))) <= (RW+1)'(DATA_DEPTH);
    assign cmd_ready = !tag_full && fits;
    assign cmd_acc   = cmd_valid && cmd_ready;

    assign rvalid    = !data_empty && !tag_empty;
    assign r_hs      = rvalid && rready;
    assign head_last = (beat_q == tag_head.len);

    assign rid   = rvalid ? ID_W'(tag_head.id) : '0;
    assign rdata = rvalid ? data_head : '0;
    assign rlast = rvalid && head_last;
    assign rresp = RRESP_OKAY;
    assign ovf_err = ovf_q;

    sal_sync_fifo #(
        .WIDTH ($bits(rd_tag_t)),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (cmd_acc),
        .wr_data_i (tag_in),
        .rd_en_i   (r_hs && head_last),
        .rd_data_o (tag_head),
        .empty_o   (tag_empty),
        .full_o    (tag_full)
    );

    sal_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DATA_DEPTH)
    ) u_data_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (dfi_rddata_valid),
        .wr_data_i (dfi_rddata),
        .rd_en_i   (r_hs),
        .rd_data_o (data_head),
        .empty_o   (data_empty),
        .full_o    (data_full)
    );

    always_comb begin
        resv_d = resv_q + (cmd_acc ? RW'(beats_of(cmd_len)) : '0) - RW'(r_hs);
        beat_d = beat_q;
        if (r_hs) begin
            beat_d = head_last ? '0 : beat_q + LEN_W'(1);
        end
        // A beat that meets a full buffer is only lost if nothing drains this cycle.
        ovf_d = ovf_q || (dfi_rddata_valid && data_full && !r_hs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resv_q <= '0;
            beat_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            resv_q <= resv_d;
            beat_q <= beat_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule
